// File: rtl/minmax_cmp_scheduler.sv
// Frame min/max tracker: one shared 16-bit magnitude comparator is time-multiplexed
// between the running-max and running-min checks of each sample.

module magnitude_comparator_16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic        a_gt_b_o,
   output logic        a_lt_b_o,
   output logic        a_eq_b_o
);
   assign a_gt_b_o = (a_i > b_i);
   assign a_lt_b_o = (a_i < b_i);
   assign a_eq_b_o = (a_i == b_i);
endmodule

// state   | meaning
// ACCEPT  | waiting for a sample (first sample of a frame loads min/max directly)
// CMP_MAX | comparator checks latched sample against running max
// CMP_MIN | comparator checks latched sample against running min
// DONE    | frame result presented, held until out_ready
module minmax_cmp_scheduler #(
   parameter int FRAME_LEN = 8,
   parameter int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_min,
   output logic [15:0]      out_max,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [IDX_W-1:0] out_max_idx
);
   typedef enum logic [1:0] {ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_t           state_q;
   logic [IDX_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [15:0]      sample_q;
   logic [15:0]      min_q;
   logic [15:0]      max_q;
   logic [IDX_W-1:0] min_idx_q;
   logic [IDX_W-1:0] max_idx_q;

   logic [15:0] cmp_b;
   logic        cmp_gt;
   logic        cmp_lt;
   logic        cmp_eq;

   assign cmp_b = (state_q == CMP_MAX) ? max_q : min_q;

   magnitude_comparator_16 u_cmp (
      .a_i      (sample_q),
      .b_i      (cmp_b),
      .a_gt_b_o (cmp_gt),
      .a_lt_b_o (cmp_lt),
      .a_eq_b_o (cmp_eq)
   );

   assign in_ready    = (state_q == ACCEPT);
   assign out_valid   = (state_q == DONE);
   assign out_min     = min_q;
   assign out_max     = max_q;
   assign out_min_idx = min_idx_q;
   assign out_max_idx = max_idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ACCEPT;
         cnt_q     <= '0;
         idx_q     <= '0;
         sample_q  <= '0;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
      end else begin
         case (state_q)
            ACCEPT: begin
               if (in_valid) begin
                  if (cnt_q == '0) begin
                     min_q     <= in_data;
                     max_q     <= in_data;
                     min_idx_q <= '0;
                     max_idx_q <= '0;
                     if (FRAME_LEN == 1) state_q <= DONE;
                     else                cnt_q   <= cnt_q + IDX_W'(1);
                  end else begin
                     sample_q <= in_data;
                     idx_q    <= cnt_q;
                     state_q  <= CMP_MAX;
                  end
               end
            end
            CMP_MAX: begin
               // strict compare: equal values keep the earlier index
               if (cmp_gt && !cmp_eq) begin
                  max_q     <= sample_q;
                  max_idx_q <= idx_q;
               end
               state_q <= CMP_MIN;
            end
            CMP_MIN: begin
               if (cmp_lt && !cmp_eq) begin
                  min_q     <= sample_q;
                  min_idx_q <= idx_q;
               end
               if (cnt_q == LAST_IDX) begin
                  state_q <= DONE;
               end else begin
                  cnt_q   <= cnt_q + IDX_W'(1);
                  state_q <= ACCEPT;
               end
            end
            DONE: begin
               if (out_ready) begin
                  cnt_q   <= '0;
                  state_q <= ACCEPT;
               end
            end
            default: state_q <= ACCEPT;
         endcase
      end
   end
endmodule

// File: tb/tb_minmax_cmp_scheduler.sv
// Bench for minmax_cmp_scheduler: directed frame table, multi-cycle corner cases,
// randomized frames against a first-occurrence min/max model, and a FRAME_LEN=1 instance.
module tb_minmax_cmp_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_data, out_min, out_max;
   logic [1:0]  out_min_idx, out_max_idx;

   logic        v1, r1, ov1, or1;
   logic [15:0] d1, mn1, mx1;
   logic        mni1, mxi1;

   minmax_cmp_scheduler #(.FRAME_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
      .out_min_idx(out_min_idx), .out_max_idx(out_max_idx));

   minmax_cmp_scheduler #(.FRAME_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
      .out_valid(ov1), .out_ready(or1), .out_min(mn1), .out_max(mx1),
      .out_min_idx(mni1), .out_max_idx(mxi1));

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0][15:0] s;
      logic [15:0]      mn;
      int               mni;
      logic [15:0]      mx;
      int               mxi;
      int               hold;
   } vec_t;

   vec_t        vecs[4];
   logic [15:0] frame_buf[4];

   function automatic vec_t mkvec(input logic [15:0] a, b, c, d, input logic [15:0] mn,
                                  input int mni, input logic [15:0] mx, input int mxi,
                                  input int hold);
      vec_t v;
      v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
      v.mn = mn; v.mni = mni; v.mx = mx; v.mxi = mxi; v.hold = hold;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // First-occurrence min/max over the frame, straight from the definition.
   task automatic model(output logic [15:0] mn, output int mni,
                        output logic [15:0] mx, output int mxi);
      mn = frame_buf[0]; mni = 0;
      mx = frame_buf[0]; mxi = 0;
      for (int i = 1; i < 4; i++) begin
         if (frame_buf[i] < mn) begin mn = frame_buf[i]; mni = i; end
         if (frame_buf[i] > mx) begin mx = frame_buf[i]; mxi = i; end
      end
   endtask

   // Caller is at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [15:0] v);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("push_timeout", 32'(n), 32'd0);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic wait_done(input int exp_lat);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("result_latency", 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_result(input logic [15:0] mn, input int mni,
                               input logic [15:0] mx, input int mxi);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_min", 32'(out_min), 32'(mn));
      chk("out_min_idx", 32'(out_min_idx), 32'(mni));
      chk("out_max", 32'(out_max), 32'(mx));
      chk("out_max_idx", 32'(out_max_idx), 32'(mxi));
   endtask

   task automatic release_result(input int hold, input logic [15:0] mn, input int mni,
                                 input logic [15:0] mx, input int mxi);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = (i % 2 == 0);
         in_data   = 16'($urandom);
         @(negedge clk);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         check_result(mn, mni, mx, mxi);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic run_frame(input int gapmax, input logic [15:0] mn, input int mni,
                            input logic [15:0] mx, input int mxi, input int hold);
      for (int i = 0; i < 4; i++) begin
         int gap;
         gap = $urandom_range(0, gapmax);
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            @(negedge clk);
         end
         push(frame_buf[i]);
      end
      wait_done(2);
      check_result(mn, mni, mx, mxi);
      release_result(hold, mn, mni, mx, mxi);
   endtask

   initial begin
      logic [15:0] emn, emx;
      int          emni, emxi;

      vecs[0] = mkvec(16'd100, 16'd50, 16'd200, 16'd50, 16'd50, 1, 16'd200, 2, 5);
      vecs[1] = mkvec(16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 3, 16'd3, 0, 1);
      vecs[2] = mkvec(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 0, 16'd7, 0, 0);
      vecs[3] = mkvec(16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 2, 16'hFFFF, 1, 2);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'd0;
      v1 = 1'b0; or1 = 1'b0; d1 = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_min", 32'(out_min), 32'd0);
      chk("rst_out_max", 32'(out_max), 32'd0);
      chk("rst_min_idx", 32'(out_min_idx), 32'd0);
      chk("rst_max_idx", 32'(out_max_idx), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 4; i++) frame_buf[i] = vecs[t].s[i];
         run_frame(0, vecs[t].mn, vecs[t].mni, vecs[t].mx, vecs[t].mxi, vecs[t].hold);
      end

      // Reset while the second sample is in CMP_MIN drops the partial frame.
      push(16'd500);
      push(16'd60000);
      @(negedge clk);
      chk("midframe_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_min", 32'(out_min), 32'd0);
      chk("midrst_out_max", 32'(out_max), 32'd0);
      chk("midrst_min_idx", 32'(out_min_idx), 32'd0);
      chk("midrst_max_idx", 32'(out_max_idx), 32'd0);
      frame_buf[0] = 16'd9; frame_buf[1] = 16'd1; frame_buf[2] = 16'd5; frame_buf[3] = 16'd1;
      run_frame(0, 16'd1, 1, 16'd9, 0, 1);

      for (int f = 0; f < 30; f++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int i = 0; i < 4; i++) begin
            case (mode)
               0:       frame_buf[i] = 16'($urandom);
               1:       frame_buf[i] = 16'($urandom_range(0, 3));
               default: frame_buf[i] = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
            endcase
         end
         model(emn, emni, emx, emxi);
         run_frame(3, emn, emni, emx, emxi, $urandom_range(0, 3));
      end

      // FRAME_LEN=1: every accepted sample is a complete frame.
      v1 = 1'b1; d1 = 16'd42; or1 = 1'b1;
      @(negedge clk);
      chk("fl1_valid_a", 32'(ov1), 32'd1);
      chk("fl1_min_a", 32'(mn1), 32'd42);
      chk("fl1_max_a", 32'(mx1), 32'd42);
      chk("fl1_idx_a", 32'({mni1, mxi1}), 32'd0);
      d1 = 16'd17;
      @(negedge clk);
      chk("fl1_gap_valid", 32'(ov1), 32'd0);
      chk("fl1_gap_ready", 32'(r1), 32'd1);
      @(negedge clk);
      v1 = 1'b0;
      chk("fl1_valid_b", 32'(ov1), 32'd1);
      chk("fl1_min_b", 32'(mn1), 32'd17);
      chk("fl1_max_b", 32'(mx1), 32'd17);
      chk("fl1_idx_b", 32'({mni1, mxi1}), 32'd0);
      @(negedge clk);
      or1 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/minmax_cmp_scheduler.md
# minmax_cmp_scheduler

Sequential min/max tracker that time-shares a single `magnitude_comparator_16` instance to find the minimum and maximum of each fixed-length frame of 16-bit samples. It sits between a valid/ready sample stream and a downstream result consumer. It schedules two comparisons per sample (against the running max, then the running min) through the one comparator, and reports values plus first-occurrence indices.

## Interface
Parameters:
- `FRAME_LEN`, default 8, is the number of samples per frame. Legal range is 1..256.
- `IDX_W`, default `$clog2(FRAME_LEN)` (min 1), is the width of the index and counter fields.

Ports:
- `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `in_valid`, input, 1 bit: sample offered.
- `in_ready`, output, 1 bit: block can accept a sample.
- `in_data`, input, 16 bits: unsigned sample.
- `out_valid`, output, 1 bit: frame result available.
- `out_ready`, input, 1 bit: consumer takes the result.
- `out_min`, output, 16 bits: frame minimum.
- `out_max`, output, 16 bits: frame maximum.
- `out_min_idx`, output, `IDX_W` bits: position in the frame of the first occurrence of the minimum.
- `out_max_idx`, output, `IDX_W` bits: position in the frame of the first occurrence of the maximum.

## Operation
- The block contains exactly one `magnitude_comparator_16`. Its operands are muxed by state:
  - `A` = registered sample, `B` = running max in CMP_MAX.
  - `A` = registered sample, `B` = running min in all other states.
- FSM states are ACCEPT, CMP_MAX, CMP_MIN and DONE. The reset state is ACCEPT.
- `in_ready` = (state == ACCEPT). `out_valid` = (state == DONE).
- ACCEPT, on `in_valid && in_ready`:
  - If `cnt == 0`: load min = max = `in_data`, min_idx = max_idx = 0. Then go to DONE if `FRAME_LEN == 1`; otherwise `cnt++` and stay in ACCEPT.
  - Otherwise: latch `in_data` into the sample register and `cnt` into the sample index, then go to CMP_MAX.
- CMP_MAX: if `A_gt_B`, max ← sample and max_idx ← index. Go to CMP_MIN.
- CMP_MIN: if `A_lt_B`, min ← sample and min_idx ← index.
  - If `cnt == FRAME_LEN-1`, go to DONE.
  - Otherwise `cnt++` and go to ACCEPT.
- DONE: all outputs are held stable. On `out_ready`, set `cnt` ← 0 and go to ACCEPT.
- Ties use strict comparisons (`A_eq_B` never updates), so the earliest index wins.
- All arithmetic is unsigned 16-bit. `cnt` never exceeds `FRAME_LEN-1`, so there is no wrap.
- Outputs are the working registers. They are meaningful only while `out_valid == 1`, and they may change mid-frame.
- `rst` asserted in any state, including mid-frame or in DONE:
  - The next state is ACCEPT.
  - The partial frame is discarded.
  - The result is dropped even if not yet taken.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0.
  - `out_min`, `out_max`, `out_min_idx`, `out_max_idx` = 0.
  - `cnt` = 0, sample register = 0.
- Per-sample occupancy:
  - The first sample of a frame takes 1 cycle (no comparison).
  - Each later sample takes 3 cycles: ACCEPT, CMP_MAX, CMP_MIN.
  - `in_ready` is low during CMP_MAX, CMP_MIN and DONE.
- Minimum frame time with `in_valid` held high and `out_ready` held high: `1 + 3*(FRAME_LEN-1)` cycles to DONE, plus 1 cycle in DONE.
- Result latency: if the last sample is accepted at edge k, `out_valid` is high after edge k+2. For `FRAME_LEN == 1`, `out_valid` is high after edge k.
- Output handshake: the result is consumed at the edge where `out_valid && out_ready`. `in_ready` returns high after that edge, so there is no same-cycle accept in DONE.
- `in_valid` in a non-ACCEPT state is ignored. `in_data` need not be held.
- `out_ready` outside DONE is ignored.
- Comparator path: register → mux → comparator → register. The whole path is one cycle.

## Test plan
All scenarios use `FRAME_LEN` = 4 unless stated.
- Mixed frame {100, 50, 200, 50} → min 50, min_idx 1; max 200, max_idx 2. `out_valid` rises 2 cycles after the 4th accept.
- All equal {7, 7, 7, 7} → min = max = 7, both idx 0 (tie rule).
- Extremes {0x8000, 0xFFFF, 0x0000, 0xFFFF} → max 0xFFFF idx 1, min 0x0000 idx 2.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE.
  - Outputs are stable, `in_ready` = 0, and `in_valid` pulses are ignored.
  - After the `out_ready` pulse, the next frame {3, 2, 1, 0} gives min 0 idx 3, max 3 idx 0.
- Reset mid-frame: assert `rst` after 2 samples (in CMP_MIN).
  - On the next cycle, all outputs are 0 and `in_ready` = 1.
  - A fresh frame {9, 1, 5, 1} → min 1 idx 1, max 9 idx 0.
- `FRAME_LEN` = 1, stream {42, 17} with `out_ready` = 1 → two results: 42/42 idx 0, then 17/17 idx 0. Each `out_valid` occurs in the cycle after its accept.
